// File: rtl/jtag_tdo_mux.sv
// TDO output stage for a JTAG TAP: selects the IR or one data register as the serial source,
// retimes it on falling TCK with a pad enable, and counts the bits shifted in each DR scan.
module jtag_tdo_mux #(
  parameter int CHANNELS    = 6,
  parameter int CODE_W      = 4,
  parameter int BYPASS_CODE = 0,
  parameter int RESET_CODE  = 2,
  parameter int CNT_W       = 16
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic [CODE_W-1:0]   CODE,
  input  logic                UPDATE_IR,
  input  logic                SHIFT_IR,
  input  logic                SHIFT_DR,
  input  logic                IR_TDO,
  input  logic [CHANNELS-1:0] DR_TDO,
  input  logic [CHANNELS-1:0] CHANNEL_EN,
  output logic                TDO,
  output logic                TDO_EN,
  output logic [CODE_W-1:0]   SEL,
  output logic                BAD_CODE,
  output logic [CNT_W-1:0]    SHIFT_COUNT
);

  localparam int SLOTS = 1 << CODE_W;

  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_IR_SCAN,
    MODE_DR_SCAN
  } mode_e;

  mode_e            mode;
  mode_e            next_mode;
  logic [SLOTS-1:0] en_ext;
  logic [SLOTS-1:0] dr_ext;
  logic             code_legal;

  // Zero-padding up to every encodable code makes codes >= CHANNELS read as disabled,
  // so one lookup covers both the range check and the enable check.
  assign en_ext     = SLOTS'(CHANNEL_EN);
  assign dr_ext     = SLOTS'(DR_TDO);
  assign code_legal = en_ext[CODE];

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    next_mode = MODE_IDLE;
    if (SHIFT_IR)      next_mode = MODE_IR_SCAN;
    else if (SHIFT_DR) next_mode = MODE_DR_SCAN;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      mode        <= MODE_IDLE;
      SEL         <= CODE_W'(RESET_CODE);
      BAD_CODE    <= 1'b0;
      SHIFT_COUNT <= '0;
    end else begin
      mode <= next_mode;

      if (UPDATE_IR) begin
        if (code_legal) begin
          SEL      <= CODE;
          BAD_CODE <= 1'b0;
        end else begin
          SEL      <= CODE_W'(BYPASS_CODE);
          BAD_CODE <= 1'b1;
        end
      end

      // The first DR cycle restarts the count at 1; later cycles saturate at all-ones.
      if (next_mode == MODE_DR_SCAN) begin
        if (mode != MODE_DR_SCAN)  SHIFT_COUNT <= CNT_W'(1);
        else if (~&SHIFT_COUNT)    SHIFT_COUNT <= SHIFT_COUNT + CNT_W'(1);
      end
    end
  end

  // Falling-edge retiming gives the pad half a TCK of setup before the capturing rising edge.
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      case (mode)
        MODE_IR_SCAN: begin
          TDO    <= IR_TDO;
          TDO_EN <= 1'b1;
        end
        MODE_DR_SCAN: begin
          TDO    <= dr_ext[SEL];
          TDO_EN <= 1'b1;
        end
        default: begin
          TDO    <= 1'b0;
          TDO_EN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tdo_mux.sv
// Self-checking bench for jtag_tdo_mux: directed scenarios plus a random run, compared against
// a run-length reference model; a second instance with a 4-bit counter covers saturation.
module tb_jtag_tdo_mux;

  localparam int CH = 6;

  logic          TCK = 1'b0;
  logic          TRST;
  logic [3:0]    CODE;
  logic          UPDATE_IR, SHIFT_IR, SHIFT_DR, IR_TDO;
  logic [CH-1:0] DR_TDO, CHANNEL_EN;

  logic          tdo, tdo_en, bad;
  logic [3:0]    sel;
  logic [15:0]   cnt;
  logic          s_tdo, s_tdo_en, s_bad;
  logic [3:0]    s_sel;
  logic [3:0]    s_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   m_sel;
  bit   m_bad;
  int   m_run;
  bit   m_ir, m_dr;
  bit   m_tdo, m_tdo_en;

  always #5 TCK = ~TCK;

  jtag_tdo_mux dut (
    .TCK(TCK), .TRST(TRST), .CODE(CODE), .UPDATE_IR(UPDATE_IR), .SHIFT_IR(SHIFT_IR),
    .SHIFT_DR(SHIFT_DR), .IR_TDO(IR_TDO), .DR_TDO(DR_TDO), .CHANNEL_EN(CHANNEL_EN),
    .TDO(tdo), .TDO_EN(tdo_en), .SEL(sel), .BAD_CODE(bad), .SHIFT_COUNT(cnt)
  );

  jtag_tdo_mux #(.CNT_W(4)) dut_sat (
    .TCK(TCK), .TRST(TRST), .CODE(CODE), .UPDATE_IR(UPDATE_IR), .SHIFT_IR(SHIFT_IR),
    .SHIFT_DR(SHIFT_DR), .IR_TDO(IR_TDO), .DR_TDO(DR_TDO), .CHANNEL_EN(CHANNEL_EN),
    .TDO(s_tdo), .TDO_EN(s_tdo_en), .SEL(s_sel), .BAD_CODE(s_bad), .SHIFT_COUNT(s_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_sel = 2; m_bad = 0; m_run = 0;
    m_ir = 0; m_dr = 0; m_tdo = 0; m_tdo_en = 0;
  endtask

  // One TCK cycle; inputs are already driven (just after a falling edge).
  task automatic step(input string tag);
    int  c;
    bit  legal;
    @(posedge TCK);
    if (UPDATE_IR) begin
      c     = int'(CODE);
      legal = (c < CH) && CHANNEL_EN[c % CH];
      m_sel = legal ? c : 0;
      m_bad = !legal;
    end
    if (!SHIFT_IR && SHIFT_DR) m_run = m_dr ? m_run + 1 : 1;
    m_dr = !SHIFT_IR && SHIFT_DR;
    m_ir = SHIFT_IR;
    #1;
    check({tag, ".sel"},   32'(sel),   32'(m_sel));
    check({tag, ".bad"},   32'(bad),   32'(m_bad));
    check({tag, ".cnt"},   32'(cnt),   32'(min_i(m_run, 65535)));
    check({tag, ".cnt4"},  32'(s_cnt), 32'(min_i(m_run, 15)));
    @(negedge TCK);
    m_tdo_en = m_ir || m_dr;
    m_tdo    = m_ir ? IR_TDO : (m_dr ? DR_TDO[m_sel] : 1'b0);
    #1;
    check({tag, ".tdo"},    32'(tdo),    32'(m_tdo));
    check({tag, ".tdo_en"}, 32'(tdo_en), 32'(m_tdo_en));
  endtask

  task automatic idle_inputs();
    UPDATE_IR = 0; SHIFT_IR = 0; SHIFT_DR = 0; IR_TDO = 0; DR_TDO = '0;
  endtask

  // Assert TRST between edges and check the async clear before any further TCK edge.
  task automatic do_reset(input string tag);
    @(posedge TCK);
    #2 TRST = 1'b0;
    #1;
    model_reset();
    check({tag, ".sel"},    32'(sel),    32'd2);
    check({tag, ".bad"},    32'(bad),    32'd0);
    check({tag, ".tdo"},    32'(tdo),    32'd0);
    check({tag, ".tdo_en"}, 32'(tdo_en), 32'd0);
    check({tag, ".cnt"},    32'(cnt),    32'd0);
    check({tag, ".cnt4"},   32'(s_cnt),  32'd0);
    @(negedge TCK);
    #1;
    idle_inputs();
    TRST = 1'b1;
  endtask

  task automatic select(input logic [3:0] code, input string tag);
    CODE = code; UPDATE_IR = 1;
    step(tag);
    UPDATE_IR = 0;
  endtask

  initial begin
    TRST = 1'b0; CODE = '0; CHANNEL_EN = 6'h3F;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge TCK);
    #1;
    check("por.sel",    32'(sel),    32'd2);
    check("por.tdo_en", 32'(tdo_en), 32'd0);
    check("por.cnt",    32'(cnt),    32'd0);
    TRST = 1'b1;

    // Disturb state, then reset between edges
    select(4'd4, "pre");
    SHIFT_DR = 1; DR_TDO = 6'h3F;
    repeat (3) step("pre_scan");
    do_reset("rst_mid_clock");

    // 8-bit DR scan on the reset channel with alternating data
    for (int i = 0; i < 8; i++) begin
      SHIFT_DR = 1; DR_TDO = '0; DR_TDO[2] = (i % 2 == 0);
      step("scan8");
    end
    idle_inputs();
    step("scan8_end");
    check("scan8.count", 32'(cnt), 32'd8);

    // Legal select, 5-bit scan of channel 3
    select(4'd3, "sel3");
    check("sel3.value", 32'(sel), 32'd3);
    for (int i = 0; i < 5; i++) begin
      SHIFT_DR = 1; DR_TDO = 6'b001000;
      step("scan5");
    end
    idle_inputs();
    step("scan5_end");
    check("scan5.tdo_en_off", 32'(tdo_en), 32'd0);

    // Illegal codes fall back to BYPASS
    select(4'd9, "code9");
    check("code9.bad", 32'(bad), 32'd1);
    CHANNEL_EN = 6'h2F;
    select(4'd4, "code4_dis");
    check("code4_dis.sel", 32'(sel), 32'd0);
    select(4'd1, "code1");
    check("code1.bad", 32'(bad), 32'd0);
    CHANNEL_EN = 6'h00;
    step("en_change_after");

    // IR scan leaves the counter alone; IR wins when both shifts are asserted
    CHANNEL_EN = 6'h3F;
    for (int i = 0; i < 4; i++) begin
      SHIFT_IR = 1; IR_TDO = 1;
      step("irscan");
    end
    for (int i = 0; i < 4; i++) begin
      SHIFT_IR = 1; SHIFT_DR = 1; IR_TDO = i[0]; DR_TDO = {CH{~i[0]}};
      step("both");
    end
    idle_inputs();
    step("both_end");

    // Saturation on the 4-bit instance, then a fresh short scan
    for (int i = 0; i < 20; i++) begin
      SHIFT_DR = 1; DR_TDO = 6'(i);
      step("sat20");
    end
    check("sat20.final", 32'(s_cnt), 32'd15);
    idle_inputs();
    step("sat20_end");
    for (int i = 0; i < 3; i++) begin
      SHIFT_DR = 1;
      step("scan3");
    end
    idle_inputs();
    step("scan3_end");
    check("scan3.count4", 32'(s_cnt), 32'd3);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      UPDATE_IR  = ($urandom % 6) == 0;
      CODE       = 4'($urandom);
      CHANNEL_EN = 6'($urandom) | 6'h01;
      SHIFT_IR   = ($urandom % 8) == 0;
      SHIFT_DR   = ($urandom % 4) != 0;
      IR_TDO     = 1'($urandom);
      DR_TDO     = 6'($urandom);
      step("rand");
    end
    idle_inputs();
    CHANNEL_EN = 6'h3F;
    step("rand_end");

    // Reset in the middle of a DR scan on a non-reset channel
    select(4'd5, "sel5");
    for (int i = 0; i < 5; i++) begin
      SHIFT_DR = 1; DR_TDO = 6'b100000;
      step("scan_rst");
    end
    check("scan_rst.tdo_en_on", 32'(tdo_en), 32'd1);
    do_reset("rst_mid_scan");
    step("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_tdo_mux.md
# jtag_tdo_mux

Parametrised TDO output stage for the JTAG TAP. It selects the serial output of one of `CHANNELS` data registers, or the instruction register, according to the instruction latched at Update-IR. Illegal or disabled instruction codes fall back to BYPASS. The output is retimed on the falling edge of TCK with an output-enable, and the block counts the bits shifted through the current DR scan for debug readout. It sits between the TAP controller/IR decode and the TDO pad.

## Interface
Parameters:
- `CHANNELS`, 6: number of data-register TDO inputs; channel index equals instruction code.
- `CODE_W`, 4: instruction code width; requires 2^`CODE_W` >= `CHANNELS`.
- `BYPASS_CODE`, 0: fallback code; must be < `CHANNELS`.
- `RESET_CODE`, 2: code selected after reset (DEVICE_ID); must be < `CHANNELS`.
- `CNT_W`, 16: width of the shift-bit counter.

Ports:
- `TCK` in 1: JTAG clock, the only clock. Rising and falling edges are both used.
- `TRST` in 1: asynchronous, active-low reset.
- `CODE` in `CODE_W`: instruction from the IR update stage.
- `UPDATE_IR` in 1: high for the TCK cycle the TAP is in Update-IR.
- `SHIFT_IR` in 1: TAP in Shift-IR.
- `SHIFT_DR` in 1: TAP in Shift-DR.
- `IR_TDO` in 1: instruction register serial out.
- `DR_TDO` in `CHANNELS`: bit i is the serial out of data register i.
- `CHANNEL_EN` in `CHANNELS`: bit i=1 means code i is legal.
- `TDO` out 1: retimed serial output.
- `TDO_EN` out 1: pad output enable.
- `SEL` out `CODE_W`: currently selected channel.
- `BAD_CODE` out 1: last Update-IR carried an illegal code.
- `SHIFT_COUNT` out `CNT_W`: bits shifted in the current or last DR scan.

## Operation
- Reset values (`TRST`=0, asynchronous): `SEL`=`RESET_CODE`, `BAD_CODE`=0, `TDO`=0, `TDO_EN`=0, `SHIFT_COUNT`=0, mode=IDLE.
- Select register (rising `TCK`, when `UPDATE_IR`=1):
  - Legal code: `CODE` < `CHANNELS` and `CHANNEL_EN[CODE]`=1. Then `SEL`<=`CODE` and `BAD_CODE`<=0.
  - Any other code: `SEL`<=`BYPASS_CODE` and `BAD_CODE`<=1.
  - `SEL` does not change at any other time. Changes to `CHANNEL_EN` after the update do not affect `SEL`.
- Mode FSM (rising `TCK`), states IDLE, IR_SCAN, DR_SCAN:
  - Any state -> IR_SCAN when `SHIFT_IR`=1.
  - Any state -> DR_SCAN when `SHIFT_IR`=0 and `SHIFT_DR`=1.
  - Any state -> IDLE when neither is asserted.
  - If `SHIFT_IR` and `SHIFT_DR` are both asserted, this is an illegal input. IR takes priority everywhere.
- Output path (falling `TCK`):
  - In IR_SCAN: `TDO`<=`IR_TDO`, `TDO_EN`<=1.
  - In DR_SCAN: `TDO`<=`DR_TDO[SEL]`, `TDO_EN`<=1.
  - In IDLE: `TDO`<=0, `TDO_EN`<=0.
- Shift counter (rising `TCK`):
  - On IDLE/IR_SCAN -> DR_SCAN entry (first cycle with `SHIFT_DR`=1 and IR not asserted): `SHIFT_COUNT`<=1.
  - Each further DR_SCAN cycle: increment by 1, saturating at 2^`CNT_W`-1.
  - Outside DR_SCAN the counter holds its value. IR scans do not touch it.
- Mid-operation reset: `TRST` low during a scan forces all reset values immediately, with no TCK edge needed. The scan in progress is discarded.

## Timing
- `UPDATE_IR` sampled at rising edge N: `SEL`/`BAD_CODE` are valid after edge N. A DR scan beginning at edge N+1 or later uses the new `SEL`.
- `SHIFT_DR` first seen high at rising edge N: mode=DR_SCAN after edge N. `TDO`/`TDO_EN` update at the falling edge between N and N+1, a half-cycle latency. The first bit captured by the DR appears there.
- `SHIFT_DR` first seen low at rising edge M: `TDO_EN`=0 and `TDO`=0 from the falling edge after M.
- `SHIFT_COUNT` equals the number of rising edges in the scan with `SHIFT_DR`=1. It is valid one cycle after the scan ends.
- `DR_TDO`/`IR_TDO` must be stable from the rising edge to the following falling edge. No combinational path runs from inputs to `TDO`.

## Test plan
- Reset: `TRST`=0 mid-clock -> `SEL`=2, `TDO_EN`=0, `TDO`=0, `SHIFT_COUNT`=0 immediately. Release, then 8-cycle DR scan with `DR_TDO[2]` toggling 1,0,1,… -> `TDO` shows the same pattern on falling edges, `SHIFT_COUNT`=8.
- Legal select: `CHANNEL_EN`=6'h3F, `CODE`=3, pulse `UPDATE_IR` -> `SEL`=3, `BAD_CODE`=0. 5-bit DR scan with `DR_TDO[3]`=1 and others 0 -> `TDO`=1 for 5 falling edges, then 0 with `TDO_EN`=0.
- Illegal codes:
  - `CODE`=9 -> `SEL`=0, `BAD_CODE`=1.
  - `CHANNEL_EN[4]`=0 with `CODE`=4 -> `SEL`=0, `BAD_CODE`=1.
  - `CODE`=1 afterwards -> `BAD_CODE`=0.
- IR scan and priority:
  - `SHIFT_IR`=1 for 4 cycles, `IR_TDO`=1 -> `TDO`=1, `TDO_EN`=1, `SHIFT_COUNT` unchanged.
  - `SHIFT_IR`=`SHIFT_DR`=1 -> `TDO` follows `IR_TDO`.
- Saturation: `CNT_W`=4, 20-cycle DR scan -> `SHIFT_COUNT` reaches 15 and holds. A new 3-cycle scan -> 3.
- Reset mid-scan: `TRST` low at bit 6 of a DR scan -> `TDO_EN`=0, `SEL`=2, `SHIFT_COUNT`=0 without a TCK edge.
